pdm_cic_decoder: RTL

- Receive-side counterpart of the sawtooth generator's 1-bit PDM output.
- Recovers unsigned SAMPLE_W-bit PCM samples from a PDM bitstream using a fixed 3rd-order CIC decimator: 3 integrators, a decimate-by-2^DECIM_LOG2 counter, 3 comb stages, then scaling and saturation.
- Presents samples on a valid/ready port with a one-entry holding register and a sticky overrun flag.
- Used on-chip for loopback self-test and in benches as a reference demodulator.

---
 rtl/pdm_cic_decoder_pkg.sv | 16 +
 rtl/pdm_cic_decoder_if.sv | 29 ++
 rtl/pdm_cic_decoder_integrator.sv | 21 ++
 rtl/pdm_cic_decoder.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pdm_cic_decoder_pkg.sv
// Shared constants and width helpers for the 3rd-order CIC PDM decoder.
// Accumulator width and output shift derive from the decimation ratio.
package pdm_pkg;

   localparam int CIC_ORDER = 3;

   function automatic int cic_acc_width(input int decim_log2);
      return CIC_ORDER * decim_log2 + 1;
   endfunction

   function automatic int cic_shift(input int decim_log2,
                                    input int sample_w);
      return CIC_ORDER * decim_log2 - sample_w;
   endfunction

endpackage

// File: rtl/pdm_cic_decoder_if.sv
// Sample delivery bus: valid/ready sample port plus sticky overrun flag.
// master = decoder side, slave = consumer side.
interface pdm_cic_decoder_if #(
   parameter int SAMPLE_W = 8
);

   logic [SAMPLE_W-1:0] sample_out;
   logic                sample_valid;
   logic                sample_ready;
   logic                overrun;
   logic                overrun_clr;

   modport master (
      output sample_out,
      output sample_valid,
      output overrun,
      input  sample_ready,
      input  overrun_clr
   );

   modport slave (
      input  sample_out,
      input  sample_valid,
      input  overrun,
      output sample_ready,
      output overrun_clr
   );

endinterface

// File: rtl/pdm_cic_decoder_integrator.sv
// One CIC integrator: W-bit enabled accumulator, modulo 2^W wraparound.
// Async active-high reset clears the running sum.
module cic_integrator_stage #(
   parameter int W = 19
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] acc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + din;
      end
   end

endmodule

// File: rtl/pdm_cic_decoder.sv
// PDM to PCM decoder: 3rd-order CIC decimator, saturating scale, sample port.
// Define PDM_IN_SYNC_EN to put a 2-flop synchronizer on pdm_in.
module pdm_cic_decoder
   import pdm_pkg::*;
#(
   parameter int DECIM_LOG2 = 6,
   parameter int SAMPLE_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  pdm_in,
   pdm_cic_decoder_if.master     sbus
);

   localparam int W     = cic_acc_width(DECIM_LOG2);
   localparam int SHIFT = cic_shift(DECIM_LOG2, SAMPLE_W);

   logic                  x;
   logic [W-1:0]          i1;
   logic [W-1:0]          i2;
   logic [W-1:0]          i3;
   logic [DECIM_LOG2-1:0] cnt;
   logic                  dec_edge;
   logic [W-1:0]          d1;
   logic [W-1:0]          d2;
   logic [W-1:0]          d3;
   logic [W-1:0]          c1;
   logic [W-1:0]          c2;
   logic [W-1:0]          c3;
   logic [SAMPLE_W:0]     v;
   logic [SAMPLE_W-1:0]   sat;
   logic                  ovr_set;

`ifdef PDM_IN_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], pdm_in};
      end
   end

   assign x = sync_q[1];
`else
   assign x = pdm_in;
`endif

   cic_integrator_stage #(.W(W)) u_int1 (
      .clk (clk),
      .rst (rst),
      .en  (ena),
      .din ({{(W-1){1'b0}}, x}),
      .acc (i1)
   );

   cic_integrator_stage #(.W(W)) u_int2 (
      .clk (clk),
      .rst (rst),
      .en  (ena),
      .din (i1),
      .acc (i2)
   );

   cic_integrator_stage #(.W(W)) u_int3 (
      .clk (clk),
      .rst (rst),
      .en  (ena),
      .din (i2),
      .acc (i3)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (ena) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign dec_edge = ena && (cnt == {DECIM_LOG2{1'b1}});

   // Combs run at the decimated rate on the pre-update integrator value.
   always_comb begin
      c1 = i3 - d1;
      c2 = c1 - d2;
      c3 = c2 - d3;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d1 <= '0;
         d2 <= '0;
         d3 <= '0;
      end else if (dec_edge) begin
         d1 <= i3;
         d2 <= c1;
         d3 <= c2;
      end
   end

   // Full scale lands exactly on bit SAMPLE_W, so clip it to all-ones.
   assign v   = c3[SHIFT +: SAMPLE_W+1];
   assign sat = v[SAMPLE_W] ? {SAMPLE_W{1'b1}} : v[SAMPLE_W-1:0];

   assign ovr_set = dec_edge && sbus.sample_valid && !sbus.sample_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sbus.sample_out   <= '0;
         sbus.sample_valid <= 1'b0;
      end else if (dec_edge) begin
         sbus.sample_out   <= sat;
         sbus.sample_valid <= 1'b1;
      end else if (sbus.sample_valid && sbus.sample_ready) begin
         sbus.sample_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sbus.overrun <= 1'b0;
      end else if (ovr_set) begin
         sbus.overrun <= 1'b1;
      end else if (sbus.overrun_clr) begin
         sbus.overrun <= 1'b0;
      end
   end

endmodule
